// File: rtl/wb_fifo64_pkg.sv
// Shared widths and types for the four-entry 64-bit result FIFO.
package wb_fifo64_pkg;
   localparam int DATA_W  = 64;
   localparam int DEPTH   = 4;
   localparam int PTR_W   = 2;
   localparam int CNT_W   = 3;
   localparam int TOTAL_W = 16;

   typedef logic [DATA_W-1:0]  word_t;
   typedef logic [PTR_W-1:0]   ptr_t;
   typedef logic [CNT_W-1:0]   cnt_t;
   typedef logic [TOTAL_W-1:0] total_t;

   localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
endpackage

// File: rtl/wb_fifo64_mem.sv
// 4x64 storage: one synchronous write port, one asynchronous read port, no reset.
module wb_fifo64_mem
   import wb_fifo64_pkg::*;
(
   input  logic  clk,
   input  logic  we_i,
   input  ptr_t  waddr_i,
   input  word_t wdata_i,
   input  ptr_t  raddr_i,
   output word_t rdata_o
);

   word_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read is unregistered so the pop edge can load the downstream register directly.
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/wb_fifo64.sv
// Four-deep FIFO between an upstream result stage and a downstream 64-bit register.
module wb_fifo64
   import wb_fifo64_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              drain_en,
   input  logic              flush,
   output logic              reg_we,
   output logic [DATA_W-1:0] reg_d,
   output logic [CNT_W-1:0]  count,
   output logic [TOTAL_W-1:0] wr_total
);

   ptr_t   wr_ptr_q, rd_ptr_q;
   cnt_t   count_q;
   logic   reg_we_q;
   word_t  reg_d_q;
   total_t wr_total_q;
   word_t  rd_data;
   logic   push, pop;

   assign in_ready = (count_q != CNT_FULL);
   // Pop only sees words already counted, so a word pushed this edge cannot leave until the next.
   assign push     = in_valid && in_ready && !flush;
   assign pop      = drain_en && (count_q != '0) && !flush;

   wb_fifo64_mem u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         reg_we_q   <= 1'b0;
         reg_d_q    <= '0;
         wr_total_q <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         reg_we_q <= 1'b0;
      end else begin
         reg_we_q <= pop;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + ptr_t'(1);
         end
         if (pop) begin
            rd_ptr_q   <= rd_ptr_q + ptr_t'(1);
            reg_d_q    <= rd_data;
            wr_total_q <= wr_total_q + total_t'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + cnt_t'(1);
            2'b01:   count_q <= count_q - cnt_t'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign reg_we   = reg_we_q;
   assign reg_d    = reg_d_q;
   assign count    = count_q;
   assign wr_total = wr_total_q;

endmodule

// File: tb/tb_wb_fifo64.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_wb_fifo64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] in_data = '0;
   logic        in_ready;
   logic        drain_en = 1'b0;
   logic        flush = 1'b0;
   logic        reg_we;
   logic [63:0] reg_d;
   logic [2:0]  count;
   logic [15:0] wr_total;

   wb_fifo64 dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .drain_en (drain_en),
      .flush    (flush),
      .reg_we   (reg_we),
      .reg_d    (reg_d),
      .count    (count),
      .wr_total (wr_total)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: contents as a plain queue, delivered word and running total.
   logic [63:0] mq[$];
   logic        m_we = 1'b0;
   logic [63:0] m_d = '0;
   logic [15:0] m_total = '0;
   bit          do_push, do_pop;

   logic [63:0] obs[$];
   bit          verbose = 1'b1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         mq.delete();
         m_we = 1'b0;
         m_d = '0;
         m_total = '0;
      end else if (flush) begin
         mq.delete();
         m_we = 1'b0;
      end else begin
         do_push = in_valid && (mq.size() < 4);
         do_pop  = drain_en && (mq.size() > 0);
         m_we = do_pop;
         if (do_pop) begin
            m_d = mq.pop_front();
            m_total = m_total + 16'd1;
         end
         if (do_push) mq.push_back(in_data);
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 64'(in_ready), 64'(mq.size() < 4));
      chk("count", 64'(count), 64'(mq.size()));
      chk("reg_we", 64'(reg_we), 64'(m_we));
      chk("reg_d", reg_d, m_d);
      chk("wr_total", 64'(wr_total), 64'(m_total));
   end

   // Advance one edge; inputs change 2ns after the edge, well clear of both clock edges.
   task automatic tick();
      @(posedge clk);
      #2;
      if (reset && reg_we) begin
         obs.push_back(reg_d);
         if (verbose) $display("pop word=%h total=%0d count=%0d", reg_d, wr_total, count);
      end
   endtask

   task automatic idle();
      in_valid = 1'b0;
      drain_en = 1'b0;
      flush    = 1'b0;
   endtask

   initial begin
      int n;
      bit pre_ready;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'($urandom);
         drain_en = 1'($urandom);
         flush    = 1'($urandom);
         in_data  = {$urandom, $urandom};
         tick();
      end
      chk("rst_reg_we", 64'(reg_we), 64'd0);
      chk("rst_reg_d", reg_d, 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_wr_total", 64'(wr_total), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      idle();
      reset = 1'b1;
      tick();

      // Single word: two-edge latency
      in_valid = 1'b1;
      drain_en = 1'b1;
      in_data  = 64'hDEAD_BEEF_0123_4567;
      tick();
      chk("single_count1", 64'(count), 64'd1);
      chk("single_no_bypass", 64'(reg_we), 64'd0);
      in_valid = 1'b0;
      tick();
      chk("single_reg_we", 64'(reg_we), 64'd1);
      chk("single_reg_d", reg_d, 64'hDEAD_BEEF_0123_4567);
      chk("single_count0", 64'(count), 64'd0);
      chk("single_total", 64'(wr_total), 64'd1);
      tick();
      chk("single_we_drop", 64'(reg_we), 64'd0);
      chk("single_d_hold", reg_d, 64'hDEAD_BEEF_0123_4567);

      // Fill and backpressure
      idle();
      obs.delete();
      for (int w = 1; w <= 5; w++) begin
         in_valid = 1'b1;
         in_data  = 64'(w);
         tick();
      end
      chk("fill_count", 64'(count), 64'd4);
      chk("fill_in_ready", 64'(in_ready), 64'd0);
      drain_en = 1'b1;
      n = 0;
      while (obs.size() < 5 && n < 12) begin
         pre_ready = in_ready;
         tick();
         if (in_valid && pre_ready) in_valid = 1'b0;
         n++;
      end
      chk("fill_obs_n", 64'(obs.size()), 64'd5);
      for (int i = 0; i < obs.size() && i < 5; i++) chk("fill_order", obs[i], 64'(i + 1));
      idle();
      tick();

      // Concurrent push/pop with pointer wrap
      obs.delete();
      drain_en = 1'b1;
      for (int w = 1; w <= 10; w++) begin
         in_valid = 1'b1;
         in_data  = 64'(w);
         tick();
         chk("wrap_count", 64'(count), 64'd1);
      end
      in_valid = 1'b0;
      tick();
      chk("wrap_count_end", 64'(count), 64'd0);
      chk("wrap_obs_n", 64'(obs.size()), 64'd10);
      for (int i = 0; i < obs.size() && i < 10; i++) chk("wrap_order", obs[i], 64'(i + 1));
      idle();

      // Flush drops buffered words and a concurrent push
      for (int w = 0; w < 3; w++) begin
         in_valid = 1'b1;
         in_data  = 64'(100 + w);
         tick();
      end
      chk("flush_pre_count", 64'(count), 64'd3);
      flush   = 1'b1;
      in_data = 64'd9;
      tick();
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_reg_we", 64'(reg_we), 64'd0);
      flush   = 1'b0;
      in_data = 64'd10;
      tick();
      in_valid = 1'b0;
      obs.delete();
      drain_en = 1'b1;
      tick();
      tick();
      chk("flush_obs_n", 64'(obs.size()), 64'd1);
      if (obs.size() > 0) chk("flush_next", obs[0], 64'd10);
      idle();

      // Asynchronous reset mid-stream
      for (int w = 0; w < 3; w++) begin
         in_valid = 1'b1;
         in_data  = 64'(200 + w);
         tick();
      end
      in_valid = 1'b0;
      chk("arst_pre_count", 64'(count), 64'd3);
      reset = 1'b0;
      #1;
      chk("arst_count", 64'(count), 64'd0);
      chk("arst_reg_we", 64'(reg_we), 64'd0);
      chk("arst_reg_d", reg_d, 64'd0);
      chk("arst_total", 64'(wr_total), 64'd0);
      chk("arst_in_ready", 64'(in_ready), 64'd1);
      tick();
      #1 reset = 1'b1;
      in_valid = 1'b1;
      in_data  = 64'd7;
      tick();
      in_valid = 1'b0;
      obs.delete();
      drain_en = 1'b1;
      tick();
      tick();
      chk("arst_obs_n", 64'(obs.size()), 64'd1);
      if (obs.size() > 0) chk("arst_word", obs[0], 64'd7);
      idle();

      // Randomized traffic in phases of differing pressure
      verbose = 1'b0;
      for (int ph = 0; ph < 6; ph++) begin
         for (int i = 0; i < 500; i++) begin
            in_valid = ($urandom_range(0, 3) < ((ph % 3) + 1));
            drain_en = ($urandom_range(0, 3) < (3 - (ph % 3)));
            flush    = ($urandom_range(0, 60) == 0);
            in_data  = {$urandom, $urandom};
            tick();
         end
      end
      idle();

      // Stream until the delivered-word total wraps
      in_valid = 1'b1;
      drain_en = 1'b1;
      n = 0;
      while (m_total != 16'hFFFF && n < 70000) begin
         in_data = {$urandom, $urandom};
         tick();
         n++;
      end
      chk("wrap_total_ffff", 64'(wr_total), 64'hFFFF);
      tick();
      chk("wrap_total_zero", 64'(wr_total), 64'h0);
      chk("wrap_total_we", 64'(reg_we), 64'd1);
      idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
